// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver with a received-byte FIFO.
// Checks frame errors and reports FIFO overflow (sticky).
// Optional feature: define UART_MON_LINE_DET_EN to add line_done_o.
//   line_done_o pulses for one cycle when a newline byte (8'h0A) is accepted into the FIFO.
// Handshake: the consumer takes the byte on data_o in a cycle where valid_o && ready_i.
//   data_o and valid_o never depend combinationally on ready_i.
//   ready_i has no effect while valid_o is low.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        busy_o,
  output logic                        frame_err_o,
`ifdef UART_MON_LINE_DET_EN
  output logic                        line_done_o,
`endif
  output logic                        overflow_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rxs;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic push;
  logic full;
  logic do_push;
  logic do_pop;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling; a low stop bit is reported and the receiver waits in BREAK for the line to go high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push    = (state == STOP) && (cnt == LAST) && rxs;
  assign full    = (count_o == FULL_CNT);
  assign do_pop  = valid_o && ready_i;
  assign do_push = push && (!full || do_pop);

  // FIFO storage; contents need no reset because valid_o gates them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, sticky overflow and the newline pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
`ifdef UART_MON_LINE_DET_EN
      line_done_o <= 1'b0;
`endif
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + (AW + 1)'(1);
        2'b01:   count_o <= count_o - (AW + 1)'(1);
        default: count_o <= count_o;
      endcase
      if (push && !do_push) overflow_o <= 1'b1;
`ifdef UART_MON_LINE_DET_EN
      line_done_o <= do_push && (shreg == 8'h0A);
`endif
    end
  end

  assign valid_o = (count_o != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed bench for uart_rx_monitor at CLKS_PER_BIT=32 and FIFO_DEPTH=8.
module tb_uart_rx_monitor;

  localparam int BIT = 32;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [3:0] count;
  logic       busy;
  logic       frame_err;
  logic       overflow;
`ifdef UART_MON_LINE_DET_EN
  logic       line_done;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ld_cnt = 0;
  int ld_count_seen = 0;
  logic [7:0] exp_q[$];

  uart_rx_monitor #(.CLKS_PER_BIT(BIT), .FIFO_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx_i(rx),
    .data_o(data),
    .valid_o(valid),
    .ready_i(ready),
    .count_o(count),
    .busy_o(busy),
    .frame_err_o(frame_err),
`ifdef UART_MON_LINE_DET_EN
    .line_done_o(line_done),
`endif
    .overflow_o(overflow)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
`ifdef UART_MON_LINE_DET_EN
    if (line_done === 1'b1) begin
      ld_cnt++;
      ld_count_seen = int'(count);
    end
`endif
  end

  // Driver: one 8N1 frame; called #1 after a rising edge, returns #1 after a rising edge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef UART_MON_LINE_DET_EN
    n_cmp++; if (line_done !== 1'b0) begin n_err++; $display("FAIL reset_line_done: got %b want 0", line_done); end
`endif
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h65, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", valid); end
    n_cmp++; if (data !== 8'h65) begin n_err++; $display("FAIL single_data: got %h want 65", data); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
    n_cmp++; if (fe_cnt != fe0) begin n_err++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    pop_one();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b want 0", valid); end
    // ready while empty must not disturb occupancy
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_ready_count: got %0d want 0", count); end
  endtask

  task automatic test_glitch();
    int fe0;
    int waited;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_start_busy: got %b want 1", busy); end
    rx = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < 17) begin
      @(posedge clk);
      #1 waited++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_drop: got %b want 0 within 17 cycles", busy); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b want 0", busy); end
    n_cmp++; if (fe_cnt != fe0) begin n_err++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    int waited;
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ferr_count: got %0d want 0", count); end
    rx = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < 6) begin
      @(posedge clk);
      #1 waited++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_release_busy: got %b want 0", busy); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL ferr_single_pulse: got %0d want 1", fe_cnt - fe0); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    exp_q.delete();
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
      if (i <= 8) exp_q.push_back(8'(i));
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    exp = exp_q.pop_front();
    n_cmp++; if (data !== exp) begin n_err++; $display("FAIL ovf_head: got %h want %h", data, exp); end
    // The stop-bit sample lands on the 307th rising edge after the frame starts; pop in that same cycle.
    fork
      send_byte(8'h0A, 1'b1);
      begin
        repeat (306) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    exp_q.push_back(8'h0A);
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 8", count); end
    for (int k = 0; k < 8; k++) begin
      exp = exp_q.pop_front();
      n_cmp++; if (data !== exp) begin n_err++; $display("FAIL drain_data%0d: got %h want %h", k, data, exp); end
      pop_one();
    end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int fe0;
    b = 8'h3C;
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = b[4];
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", data); end
    rst = 1'b0;
    fe0 = fe_cnt;
    repeat (400) @(posedge clk);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL midrst_nopush: got %0d want 0", count); end
    n_cmp++; if (fe_cnt != fe0) begin n_err++; $display("FAIL midrst_noerr: got %0d pulses want 0", fe_cnt - fe0); end
    send_byte(8'h3C, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (data !== 8'h3C) begin n_err++; $display("FAIL midrst_next_data: got %h want 3c", data); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL midrst_next_count: got %0d want 1", count); end
    pop_one();
  endtask

`ifdef UART_MON_LINE_DET_EN
  task automatic test_line_det();
    int ld0;
    ld0 = ld_cnt;
    send_byte(8'h6F, 1'b1);
    send_byte(8'h6B, 1'b1);
    n_cmp++; if (ld_cnt != ld0) begin n_err++; $display("FAIL line_early: got %0d pulses want 0", ld_cnt - ld0); end
    send_byte(8'h0A, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ld_cnt - ld0 != 1) begin n_err++; $display("FAIL line_pulses: got %0d want 1", ld_cnt - ld0); end
    n_cmp++; if (ld_count_seen != 3) begin n_err++; $display("FAIL line_coincide: count at pulse %0d want 3", ld_count_seen); end
    n_cmp++; if (data !== 8'h6F) begin n_err++; $display("FAIL line_head: got %h want 6f", data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_MON_LINE_DET_EN
    test_line_det();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 32, meaning clk cycles per UART bit (100 MHz / 3125000 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx_i  input  1  serial line from DUT uart_tx; asynchronous; idle high.
REQ-006 SHALL have port data_o  output  8  byte at FIFO head.
REQ-007 SHALL have port valid_o  output  1  FIFO not empty.
REQ-008 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-009 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-010 SHALL have port busy_o  output  1  receiver not in IDLE.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port overflow_o  output  1  sticky; byte dropped because FIFO full.
REQ-013 SHALL have port line_done_o  output  1  one-cycle pulse on 8'h0A push; present only with UART_MON_LINE_DET_EN.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer reset to 1; all decisions use synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK; a bit counter (0..CLKS_PER_BIT-1) and a 3-bit index.
REQ-016 SHALL, in IDLE, on rxs==0 enter START with counter cleared.
REQ-017 SHALL, in START, sample rxs when counter reaches CLKS_PER_BIT/2-1: 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, nothing reported).
REQ-018 SHALL, in DATA, sample rxs each time counter reaches CLKS_PER_BIT-1, shifting LSB first; after index 7 enter STOP.
REQ-019 SHALL, in STOP, sample at counter CLKS_PER_BIT-1: 1 -> push byte, IDLE; 0 -> frame_err_o pulse next cycle, byte discarded, BREAK.
REQ-020 SHALL, in BREAK, remain until rxs==1, then IDLE.
REQ-021 SHALL make a pushed byte visible on valid_o/data_o the cycle after the stop-bit sample cycle (if FIFO was empty).
REQ-022 SHALL pop on valid_o && ready_i; data_o advances next cycle; ready_i with valid_o low has no effect.
REQ-023 SHALL, on push while full without pop, drop the new byte, set overflow_o, keep FIFO contents.
REQ-024 SHALL, on push and pop in same cycle while full, accept the push; count_o unchanged.
REQ-025 SHALL, on push and pop same cycle while empty, push only (pop ignored as valid_o was low).
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH; count_o exact at 0 and FIFO_DEPTH.
REQ-027 SHALL assert busy_o in START, DATA, STOP, BREAK.

Reset
REQ-028 SHALL, while rst high at a clk edge, force IDLE, counters 0, FIFO empty, synchronizer 1; outputs: data_o 0, valid_o 0, count_o 0, busy_o 0, frame_err_o 0, overflow_o 0, line_done_o 0.
REQ-029 SHALL abandon a frame in progress on reset with no push or error; reception restarts on next falling edge after rst low.
REQ-030 SHALL clear overflow_o only by reset.

Configuration
REQ-031 SHALL, with UART_MON_LINE_DET_EN defined, pulse line_done_o for one cycle in the cycle a byte 8'h0A is written to the FIFO (not on dropped bytes).
REQ-032 SHALL, without UART_MON_LINE_DET_EN, omit port line_done_o and its logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=32, send 8'h65 8N1, ready_i=0 -> valid_o=1, data_o=8'h65, count_o=1, frame_err_o never 1.
REQ-034 SHALL cover: rx_i low 8 cycles then high -> returns IDLE, valid_o stays 0, busy_o drops within 17 cycles.
REQ-035 SHALL cover: byte 8'hA5 with stop bit 0 -> one frame_err_o pulse, count_o 0, busy_o held until line high.
REQ-036 SHALL cover: 9 bytes 8'h01..8'h09, ready_i=0 -> count_o=8, overflow_o=1, drained order 01..08; then byte 8'h0A while popping at full -> accepted, count_o stays 8.
REQ-037 SHALL cover: rst asserted mid-DATA of 8'h3C -> all outputs reset values, no byte; next 8'h3C received correctly.
REQ-038 SHALL cover: with UART_MON_LINE_DET_EN, bytes "ok\n" -> exactly one line_done_o pulse, coincident with 8'h0A push.
